// File: rtl/e2prom_pkg.sv
// Shared types and defaults for the EEPROM request sequencer in front of i2c_dri.
// Optional watchdog is enabled by defining E2PROM_SEQ_WDOG_EN.
package e2prom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_GAP       = 3'd4,
    ST_RESP      = 3'd5
  } e2prom_seq_state_t;

  localparam int E2P_WR_WAIT_CYC   = 5000;
  localparam int E2P_RETRY_GAP_CYC = 1000;
  localparam int E2P_MAX_RETRY     = 4;
  localparam int E2P_TIMEOUT_CYC   = 65535;

  localparam logic E2P_ACK  = 1'b0;
  localparam logic E2P_NACK = 1'b1;

  function automatic int e2p_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/e2prom_cyc_timer.sv
// Loadable down-counter with zero flag, shared by write-cycle wait, retry gap and watchdog.
// Counting stops at zero; a load always takes priority over a decrement.
module e2prom_cyc_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/e2prom_seq.sv
// Single-byte EEPROM read/write sequencer driving the i2c_dri exec/done handshake,
// with write-cycle delay and bounded NACK retry. Watchdog on i2c_done: E2PROM_SEQ_WDOG_EN.
module e2prom_seq
  import e2prom_pkg::*;
#(
  parameter int WR_WAIT_CYC   = E2P_WR_WAIT_CYC,
  parameter int RETRY_GAP_CYC = E2P_RETRY_GAP_CYC,
  parameter int MAX_RETRY     = E2P_MAX_RETRY,
  parameter int TIMEOUT_CYC   = E2P_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        busy
);

`ifdef E2PROM_SEQ_WDOG_EN
  localparam int TMR_MAX = e2p_max(e2p_max(WR_WAIT_CYC, RETRY_GAP_CYC), TIMEOUT_CYC);
`else
  localparam int TMR_MAX = e2p_max(WR_WAIT_CYC, RETRY_GAP_CYC);
`endif
  localparam int TMR_W = $clog2(TMR_MAX) + 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // The state after a load lasts exactly N cycles, so the timer is loaded with N-1.
  localparam logic [TMR_W-1:0] WR_LOAD  = TMR_W'((WR_WAIT_CYC   > 0) ? WR_WAIT_CYC   - 1 : 0);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((RETRY_GAP_CYC > 0) ? RETRY_GAP_CYC - 1 : 0);
`ifdef E2PROM_SEQ_WDOG_EN
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'((TIMEOUT_CYC   > 0) ? TIMEOUT_CYC   - 1 : 0);
`endif
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(MAX_RETRY);

  e2prom_seq_state_t state_q, state_d;
  logic              rh_wl_q, rh_wl_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [RTY_W-1:0]  retry_q, retry_d;

  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;

  e2prom_cyc_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rh_wl_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      rh_wl_q <= rh_wl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rh_wl_d  = rh_wl_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    retry_d  = retry_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rh_wl_d = !req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          retry_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
`ifdef E2PROM_SEQ_WDOG_EN
        tmr_load = 1'b1;
        tmr_val  = TMO_LOAD;
`endif
      end
      ST_WAIT_DONE: begin
        // A done on the expiry edge is checked first and therefore wins.
        if (i2c_done) begin
          if (i2c_ack == E2P_ACK) begin
            if (!rh_wl_q) begin
              tmr_load = 1'b1;
              tmr_val  = WR_LOAD;
              state_d  = ST_WR_WAIT;
            end else begin
              rdata_d = i2c_data_r;
              err_d   = 1'b0;
              state_d = ST_RESP;
            end
          end else if (retry_q < RTY_LIM) begin
            retry_d  = retry_q + RTY_W'(1);
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = ST_GAP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
`ifdef E2PROM_SEQ_WDOG_EN
        else if (tmr_zero) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      ST_WR_WAIT: begin
        if (tmr_zero) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = ST_ISSUE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    i2c_exec  = (state_q == ST_ISSUE);
    rsp_valid = (state_q == ST_RESP);
  end

  assign i2c_rh_wl  = rh_wl_q;
  assign i2c_addr   = addr_q;
  assign i2c_data_w = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_e2prom_seq.sv
// Self-checking bench for e2prom_seq: directed and random transactions against a slave model
// whose expected timing/results come from attempt counts; watchdog case under E2PROM_SEQ_WDOG_EN.
module tb_e2prom_seq;

  localparam int W_CYC = 20;
  localparam int G_CYC = 8;
  localparam int MR    = 4;
  localparam int T_CYC = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        i2c_exec, i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;
  logic        i2c_done, i2c_ack;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_rdata;

  always #5 clk = ~clk;

  e2prom_seq #(
    .WR_WAIT_CYC   (W_CYC),
    .RETRY_GAP_CYC (G_CYC),
    .MAX_RETRY     (MR),
    .TIMEOUT_CYC   (T_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .i2c_exec   (i2c_exec),
    .i2c_rh_wl  (i2c_rh_wl),
    .i2c_addr   (i2c_addr),
    .i2c_data_w (i2c_data_w),
    .i2c_data_r (i2c_data_r),
    .i2c_done   (i2c_done),
    .i2c_ack    (i2c_ack),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_exec"}, i2c_exec, 0);
    chk({tag, "_rh_wl"}, i2c_rh_wl, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_addr"}, i2c_addr, 0);
    chk({tag, "_data_w"}, i2c_data_w, 0);
  endtask

  // Accept a request and leave the bench sampling in the cycle where i2c_exec should be high.
  task automatic issue_req(input bit wr, input logic [15:0] addr, input logic [7:0] wdata);
    int e;
    e = 0;
    while (!req_ready && e < 200) begin step(); e++; end
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    step();
    // Keep presenting scrambled requests while busy; they must be ignored.
    req_wr = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
    chk("accept_ready_low", req_ready, 0);
    chk("accept_busy", busy, 1);
  endtask

  // Full transaction: the slave NACKs the first `nacks` attempts, each transfer lasting `lat` cycles.
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                        input int nacks, input int lat);
    int attempts, e, bad;
    bit exp_err;
    logic [7:0] rd;
    attempts = (nacks > MR) ? MR + 1 : nacks + 1;
    exp_err  = (nacks > MR);
    rd  = 8'h00;
    bad = 0;
    issue_req(wr, addr, wdata);
    for (int a = 0; a < attempts; a++) begin
      chk("exec", i2c_exec, 1);
      chk("rh_wl", i2c_rh_wl, !wr);
      chk("i2c_addr", i2c_addr, addr);
      if (wr) chk("i2c_data_w", i2c_data_w, wdata);
      rd = 8'($urandom);
      for (int k = 1; k <= lat; k++) begin
        step();
        if (i2c_exec || rsp_valid || req_ready || i2c_addr !== addr) bad++;
        if (k == lat) begin
          i2c_done = 1'b1; i2c_ack = (a < nacks); i2c_data_r = rd;
        end
      end
      step();
      i2c_done = 1'b0; i2c_ack = 1'b0; i2c_data_r = 8'($urandom);
      e = 0;
      if (a < attempts - 1) begin
        while (!i2c_exec && e < 200) begin
          if (rsp_valid || req_ready) bad++;
          step(); e++;
        end
        chk("retry_gap_edges", e, G_CYC);
      end else begin
        while (!rsp_valid && e < 200) begin
          if (i2c_exec || req_ready) bad++;
          step(); e++;
        end
        chk("rsp_latency", e, (wr && !exp_err) ? W_CYC : 0);
      end
    end
    if (!wr && !exp_err) exp_rdata = rd;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_ready_low", req_ready, 0);
    chk("stray_activity", bad, 0);
    req_valid = 1'b0;
    step();
    chk("post_rsp_pulse", rsp_valid, 0);
    chk("post_rsp_ready", req_ready, 1);
    chk("post_rsp_busy", busy, 0);
    chk("rdata_hold", rsp_rdata, exp_rdata);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    i2c_done = 1'b0; i2c_ack = 1'b0; i2c_data_r = '0;
    exp_rdata = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    chk_reset_vals("reset");
    step();

    do_txn(1'b0, 16'h0010, 8'h00, 0, 3);     // plain read
    do_txn(1'b1, 16'h0100, 8'h5A, 0, 4);     // acked write
    do_txn(1'b1, 16'h0200, 8'hC3, 2, 2);     // two NACKs then ack
    do_txn(1'b0, 16'h0300, 8'h00, 99, 2);    // never acked: retries exhausted
    do_txn(1'b1, 16'h0301, 8'h11, 99, 1);
    do_txn(1'b0, 16'h0302, 8'h00, MR, 1);    // ack on the very last attempt

    // Reset while waiting for done, then a stray done in IDLE.
    issue_req(1'b0, 16'hBEEF, 8'h00);
    req_valid = 1'b0;
    chk("rst_test_exec", i2c_exec, 1);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rdata = 8'h00;
    chk_reset_vals("midrst");
    i2c_done = 1'b1; i2c_ack = 1'b0; i2c_data_r = 8'h77;
    step();
    i2c_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid || !req_ready || i2c_exec || rsp_rdata !== 8'h00) bad++;
      step();
    end
    chk("stray_done_ignored", bad, 0);
    do_txn(1'b0, 16'h0010, 8'h00, 0, 2);

    for (int t = 0; t < 16; t++) begin
      do_txn(1'($urandom), 16'($urandom), 8'($urandom),
             int'($urandom_range(0, 6)), int'($urandom_range(1, 6)));
    end

`ifdef E2PROM_SEQ_WDOG_EN
    begin
      int e;
      issue_req(1'b0, 16'h0440, 8'h00);
      chk("wdog_exec", i2c_exec, 1);
      e = 0;
      bad = 0;
      while (!rsp_valid && e < 500) begin
        step(); e++;
        if (i2c_exec) bad++;
      end
      chk("wdog_latency", e, T_CYC + 1);
      chk("wdog_err", rsp_err, 1);
      chk("wdog_no_retry", bad, 0);
      req_valid = 1'b0;
      step();
      chk("wdog_ready", req_ready, 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/e2prom_seq.md
# e2prom_seq

- Request sequencer between user logic and `i2c_dri`; clocked by `dri_clk`.
- Accepts single-byte EEPROM read/write requests over a valid/ready handshake and drives the `i2c_exec`/`i2c_done` handshake of `i2c_dri`.
- After every write it inserts the EEPROM internal write-cycle delay. On NACK it retries a bounded number of times.
- Returns each result as a one-cycle response pulse.

## Interface
- `WR_WAIT_CYC`, 5000: write-cycle wait after an acked write, in `clk` cycles (5 ms at 1 MHz).
- `RETRY_GAP_CYC`, 1000: idle gap before re-issuing a NACKed transfer.
- `MAX_RETRY`, 4: retries after the first attempt; total attempts = 1+`MAX_RETRY`.
- `TIMEOUT_CYC`, 65535: watchdog limit on `i2c_done` (only with the watchdog macro).
- `clk` in 1: I2C operation clock (`dri_clk`).
- `rst` in 1: reset. Synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle, can accept a request.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in 16: EEPROM word address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 8: read data; holds its value until the next read response.
- `rsp_err` out 1: valid with `rsp_valid`; 1 = NACK retries exhausted or timeout.
- `i2c_exec` out 1: one-cycle start pulse to `i2c_dri`.
- `i2c_rh_wl` out 1: 1 = read, 0 = write.
- `i2c_addr` out 16: address to `i2c_dri`.
- `i2c_data_w` out 8: write data to `i2c_dri`.
- `i2c_data_r` in 8: read data from `i2c_dri`.
- `i2c_done` in 1: transfer complete pulse from `i2c_dri`.
- `i2c_ack` in 1: 0 = all bytes acked, 1 = NACK; sampled with `i2c_done`.
- `busy` out 1: equals `!req_ready`.

## Operation
- **States:** IDLE, ISSUE, WAIT_DONE, WR_WAIT, GAP, RESP.
- **IDLE:** `req_ready`=1. When `req_valid`=1:
  - latch `req_wr`, `req_addr`, `req_wdata`;
  - clear the retry counter;
  - go to ISSUE.
- **ISSUE:** `i2c_exec`=1 for exactly one cycle, then WAIT_DONE.
  - `i2c_rh_wl`=!wr_latched.
  - `i2c_addr` and `i2c_data_w` come from the latched values and stay stable from ISSUE until the state leaves WAIT_DONE.
- **WAIT_DONE:** on `i2c_done`=1:
  - ack=0, write: go to WR_WAIT and load the timer with `WR_WAIT_CYC`.
  - ack=0, read: capture `i2c_data_r` into `rsp_rdata`, set err=0, go to RESP.
  - ack=1 and retry count < `MAX_RETRY`: increment the count, load the timer with `RETRY_GAP_CYC`, go to GAP.
  - ack=1 and retries exhausted: set err=1, go to RESP.
- **WR_WAIT:** timer reaches 0 → set err=0, go to RESP.
- **GAP:** timer reaches 0 → go to ISSUE.
- **RESP:** `rsp_valid`=1 for one cycle, then IDLE.
- **Ignored inputs:**
  - `i2c_done` in any state other than WAIT_DONE (including a stray pulse after reset).
  - `req_*` while `req_ready`=0.
- **Timer:** single down-counter, width `$clog2` of the largest loaded value +1.
- **Retry counter:** width `$clog2(MAX_RETRY+1)`. `MAX_RETRY`=0 means a single attempt.

## Timing
- **Reset values:**
  - `req_ready`=1 (reset state is IDLE), `busy`=0.
  - `rsp_valid`, `rsp_err`, `i2c_exec`, `i2c_rh_wl`=0.
  - `rsp_rdata`, `i2c_addr`, `i2c_data_w`=0.
- **Acceptance:** request accepted at edge N. `i2c_exec` is high during cycle N+1; `req_ready` is low from N+1.
- **Read latency:** `i2c_done` sampled at edge D → `rsp_valid` high during cycle D+1.
- **Write latency:** `i2c_done` at edge D → `rsp_valid` high during cycle D+`WR_WAIT_CYC`+1.
- **NACK retry:** `i2c_done` at edge D → next `i2c_exec` during cycle D+`RETRY_GAP_CYC`+1.
- **Back-to-back:** `req_ready` returns to 1 in the cycle after RESP. Minimum request spacing is therefore 4 cycles plus the `i2c_dri` transfer time.
- **Reset mid-operation:**
  - Returns to IDLE at the next edge; no response is produced.
  - A transfer already in flight inside `i2c_dri` completes on its own, and its `i2c_done` is ignored.

## Configuration
- **Macro:** `E2PROM_SEQ_WDOG_EN`.
- **Defined:** in WAIT_DONE the timer is loaded with `TIMEOUT_CYC` on entry.
  - If it expires before `i2c_done`: RESP with err=1. No retry.
  - A `i2c_done` arriving on the same edge as expiry wins.
- **Undefined:** WAIT_DONE waits indefinitely and `TIMEOUT_CYC` is unused.

## Structure
- **Shared package `e2prom_pkg`:**
  - state enum `e2prom_seq_state_t`;
  - default constants `E2P_WR_WAIT_CYC`, `E2P_RETRY_GAP_CYC`, `E2P_MAX_RETRY`;
  - the `i2c_ack` encoding constants `E2P_ACK`=0 and `E2P_NACK`=1.
- **Sub-module `e2prom_cyc_timer`:** loadable down-counter with a zero flag. It is shared by WR_WAIT, GAP and the watchdog, since only one of them is active at a time.

## Test plan
- Read 0x0010, slave model acks and returns 0xA5 → one `i2c_exec` pulse with `i2c_rh_wl`=1 and `i2c_addr`=0x0010; `rsp_valid` one cycle after `i2c_done` with `rsp_rdata`=0xA5 and `rsp_err`=0.
- Write 0x5A to 0x0100, acked, `WR_WAIT_CYC`=20 → `i2c_data_w`=0x5A; `rsp_valid` exactly 21 cycles after `i2c_done`; `req_ready`=0 throughout.
- Write, model NACKs twice then acks, `RETRY_GAP_CYC`=8 → exactly 3 `i2c_exec` pulses, each 9 cycles after the previous `i2c_done`; final `rsp_err`=0.
- Model always NACKs, `MAX_RETRY`=4 → exactly 5 `i2c_exec` pulses, then `rsp_valid` with `rsp_err`=1.
- Assert `rst` in WAIT_DONE, then send a stray `i2c_done` in IDLE → no `rsp_valid`, all outputs at their reset values, next request proceeds normally.
- With `E2PROM_SEQ_WDOG_EN` and `TIMEOUT_CYC`=50, never pulse `i2c_done` → `rsp_valid` with `rsp_err`=1 51 cycles after `i2c_exec`.
